// File: rtl/dsm_pkg.sv
// Shared sample type and interpolator state encoding for the mixer/modulator datapath.
package dsm_pkg;

  localparam int SAMPLE_W = 20;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } interp_state_t;

endpackage

// File: rtl/interp_ramp.sv
// Combinational ramp point prev + ((curr - prev) * phase) >>> LOG2_R, no latency, no flow control.
// LINEAR_INTERP_ROUND_EN adds half an LSB before the shift (round-half-up); otherwise floor.
module interp_ramp
  import dsm_pkg::*;
#(
  parameter int LOG2_R = 2
) (
  input  logic signed [SAMPLE_W-1:0] i_prev,
  input  logic signed [SAMPLE_W-1:0] i_curr,
  input  logic        [LOG2_R-1:0]   i_phase,
  output logic signed [SAMPLE_W-1:0] o_ramp
);

  localparam int PW = SAMPLE_W + 1 + LOG2_R;

  logic signed [SAMPLE_W:0] w_delta;
  logic signed [PW-1:0]     w_delta_x;
  logic signed [PW-1:0]     w_phase_x;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_biased;
  logic                     w_unused_bits;

  assign w_delta   = {i_curr[SAMPLE_W-1], i_curr} - {i_prev[SAMPLE_W-1], i_prev};
  assign w_delta_x = {{LOG2_R{w_delta[SAMPLE_W]}}, w_delta};
  assign w_phase_x = {{(SAMPLE_W + 1){1'b0}}, i_phase};
  assign w_prod    = w_delta_x * w_phase_x;

`ifdef LINEAR_INTERP_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (LOG2_R - 1);
  assign w_biased = w_prod + HALF;
`else
  assign w_biased = w_prod;
`endif

  // The shifted value always lands between prev and curr, so a 20-bit wrap-around sum is exact.
  assign o_ramp        = i_prev + w_biased[SAMPLE_W-1+LOG2_R:LOG2_R];
  assign w_unused_bits = ^{w_biased[PW-1], w_biased[LOG2_R-1:0]};

endmodule

// File: rtl/linear_interp.sv
// Upsample-by-2^LOG2_R linear interpolator; interp_o is registered, 1 clock after a RUN tick.
// in_ready stays high until the one-entry buffer fills in RUN; rounding via LINEAR_INTERP_ROUND_EN.
module linear_interp
  import dsm_pkg::*;
#(
  parameter int LOG2_R = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic signed [SAMPLE_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] interp_o,
  output logic                       underflow_o
);

  interp_state_t             r_state;
  logic signed [SAMPLE_W-1:0] r_prev;
  logic signed [SAMPLE_W-1:0] r_curr;
  logic signed [SAMPLE_W-1:0] r_nxt;
  logic                      r_nxt_v;
  logic [LOG2_R-1:0]         r_phase;
  logic signed [SAMPLE_W-1:0] r_interp;
  logic                      r_underflow;

  logic                      w_xfer;
  logic                      w_boundary;
  logic signed [SAMPLE_W-1:0] w_ramp;

  assign in_ready    = (r_state != RUN) || !r_nxt_v;
  assign w_xfer      = in_valid && in_ready;
  assign w_boundary  = (r_state == RUN) && tick && (r_phase == '1);
  assign interp_o    = r_interp;
  assign underflow_o = r_underflow;

  interp_ramp #(
    .LOG2_R (LOG2_R)
  ) u_ramp (
    .i_prev  (r_prev),
    .i_curr  (r_curr),
    .i_phase (r_phase),
    .o_ramp  (w_ramp)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_prev      <= '0;
      r_curr      <= '0;
      r_nxt       <= '0;
      r_nxt_v     <= 1'b0;
      r_phase     <= '0;
      r_interp    <= '0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_xfer) begin
            r_curr  <= in_data;
            r_state <= PRIME;
          end
        end
        PRIME: begin
          if (w_xfer) begin
            r_prev  <= r_curr;
            r_curr  <= in_data;
            r_phase <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            r_interp <= w_ramp;
            r_phase  <= r_phase + 1'b1;
            if (w_boundary) begin
              r_prev <= r_curr;
              if (r_nxt_v) begin
                r_curr <= r_nxt;
              end else begin
                r_underflow <= 1'b1;
              end
            end
          end
          // A transfer only happens with the buffer empty, so it never races a boundary load.
          if (w_xfer) begin
            r_nxt   <= in_data;
            r_nxt_v <= 1'b1;
          end else if (w_boundary && r_nxt_v) begin
            r_nxt_v <= 1'b0;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule
